// File: rtl/data_responder.sv
// -----------------------------------------------------------------------------
// data_responder
//
// Responder end of the pipeline core's data-memory port. Serves reads
// combinationally from a word-addressed data RAM or a small MMIO page, and
// commits writes on the rising clock edge. It also latches the core's halt
// request as a sticky flag.
//
// MMIO page (word aligned, addr[1:0] ignored):
//   0xFFFF0000  CYCLE   read-only free-running cycle counter (frozen while halted)
//   0xFFFF0004  TXDATA  write pushes a word into the transmit FIFO; reads return 0
//   0xFFFF0008  STATUS  {16'b0, count[7:0], 4'b0, halted, overflow, full, empty};
//                       any write clears overflow
//
// Ports:
//   clk       in   1   clock, all state updates on the rising edge
//   reset_n   in   1   asynchronous active-low reset
//   mem_en    in   1   write enable from the core's MEM stage
//   addr      in   32  byte address
//   mem_data  in   32  write data
//   req       in   1   halt request (sets sticky halted)
//   mem_out   out  32  combinational read data for addr
//   tx_valid  out  1   transmit FIFO non-empty
//   tx_data   out  32  transmit FIFO head word (0 when empty)
//   tx_ready  in   1   downstream accepts the head word
//   halted    out  1   sticky halt flag
// -----------------------------------------------------------------------------
module data_responder #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_en,
  input  logic [31:0] addr,
  input  logic [31:0] mem_data,
  input  logic        req,
  output logic [31:0] mem_out,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  output logic        halted
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Word addresses (addr[31:2]) of the MMIO registers.
  localparam logic [29:0] CYCLE_WA  = 30'h3FFF_C000;
  localparam logic [29:0] TXDATA_WA = 30'h3FFF_C001;
  localparam logic [29:0] STATUS_WA = 30'h3FFF_C002;

  // Storage arrays carry no reset: RAM contents survive reset, and FIFO slots
  // are only ever observed through the reset pointers/count.
  logic [31:0]   ram_q  [RAM_WORDS];
  logic [31:0]   fifo_q [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;
  logic          halted_q,   halted_d;
  logic [31:0]   cycle_q,    cycle_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [29:0]   word_addr;
  logic          sel_ram;
  logic          sel_cycle;
  logic          sel_tx;
  logic          sel_status;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_lsbs;

  assign word_addr        = addr[31:2];
  assign sel_ram          = (addr[31:AW+2] == '0);
  assign ram_idx          = addr[AW+1:2];
  assign sel_cycle        = (word_addr == CYCLE_WA);
  assign sel_tx           = (word_addr == TXDATA_WA);
  assign sel_status       = (word_addr == STATUS_WA);
  assign unused_addr_lsbs = ^addr[1:0];

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic push_ok;
  logic push_drop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign push       = mem_en & sel_tx;
  assign pop        = ~fifo_empty & tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // only dropped when nothing is leaving.
  assign push_ok    = push & (~fifo_full | pop);
  assign push_drop  = push & fifo_full & ~pop;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    halted_d   = halted_q | req;
    cycle_d    = cycle_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_ok) - CW'(pop);

    // A dropped push outranks a simultaneous STATUS write.
    if (push_drop) begin
      overflow_d = 1'b1;
    end else if (mem_en && sel_status) begin
      overflow_d = 1'b0;
    end

    if (!halted_q) begin
      cycle_d = cycle_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      halted_q   <= 1'b0;
      cycle_q    <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      halted_q   <= halted_d;
      cycle_q    <= cycle_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= mem_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Data RAM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_en && sel_ram) begin
      ram_q[ram_idx] <= mem_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and outputs
  // ---------------------------------------------------------------------------
  logic [31:0] status_word;
  logic [7:0]  count_ext;

  assign count_ext   = 8'(count_q);
  assign status_word = {16'h0000, count_ext, 4'h0,
                        halted_q, overflow_q, fifo_full, fifo_empty};

  always_comb begin
    mem_out = '0;
    if (sel_ram) begin
      mem_out = ram_q[ram_idx];
    end else if (sel_cycle) begin
      mem_out = cycle_q;
    end else if (sel_status) begin
      mem_out = status_word;
    end
  end

  // tx_data is forced to 0 when empty so stale slots never leak out.
  assign tx_valid = ~fifo_empty;
  assign tx_data  = fifo_empty ? '0 : fifo_q[rd_ptr_q];
  assign halted   = halted_q;

endmodule

// File: tb/tb_data_responder.sv
module tb_data_responder;

  localparam int RAM_WORDS  = 1024;
  localparam int FIFO_DEPTH = 8;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] A_TX     = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;

  logic        clk;
  logic        reset_n;
  logic        mem_en;
  logic [31:0] addr;
  logic [31:0] mem_data;
  logic        req;
  logic [31:0] mem_out;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        halted;

  int n_chk  = 0;
  int n_pass = 0;

  data_responder #(
    .RAM_WORDS (RAM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mem_en  (mem_en),
    .addr    (addr),
    .mem_data(mem_data),
    .req     (req),
    .mem_out (mem_out),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .halted  (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a queue for the FIFO, a sparse array for the RAM and
  // plain counters. Compared on every falling edge, then advanced with the
  // inputs that the next rising edge will sample.
  // ---------------------------------------------------------------------------
  logic [31:0] mq [$];
  logic [31:0] mram [int unsigned];
  logic [31:0] m_cyc  = 0;
  bit          m_halt = 0;
  bit          m_ovf  = 0;

  function automatic logic [31:0] m_status();
    logic [7:0] c;
    c = 8'(mq.size());
    return {16'h0000, c, 4'h0, m_halt, m_ovf, (mq.size() == FIFO_DEPTH), (mq.size() == 0)};
  endfunction

  initial begin
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        m_cyc  = 0;
        m_halt = 0;
        m_ovf  = 0;
      end else begin
        bit p_pop, p_push, p_drop;
        // compare
        chk("model_tx_valid", {31'b0, tx_valid}, {31'b0, mq.size() != 0});
        chk("model_tx_data", tx_data, (mq.size() != 0) ? mq[0] : 32'h0);
        chk("model_halted", {31'b0, halted}, {31'b0, m_halt});
        if (addr < 32'(4 * RAM_WORDS)) begin
          if (mram.exists(addr[31:2])) chk("model_ram_rd", mem_out, mram[addr[31:2]]);
        end else if (addr[31:2] == A_CYCLE[31:2]) begin
          chk("model_cycle_rd", mem_out, m_cyc);
        end else if (addr[31:2] == A_STATUS[31:2]) begin
          chk("model_status_rd", mem_out, m_status());
        end else begin
          chk("model_other_rd", mem_out, 32'h0);
        end
        // advance to the state after the next rising edge
        p_pop  = (mq.size() != 0) && tx_ready;
        p_push = mem_en && (addr[31:2] == A_TX[31:2]);
        p_drop = p_push && (mq.size() == FIFO_DEPTH) && !p_pop;
        if (p_drop) m_ovf = 1;
        else if (mem_en && addr[31:2] == A_STATUS[31:2]) m_ovf = 0;
        if (p_pop) void'(mq.pop_front());
        if (p_push && !p_drop) mq.push_back(mem_data);
        if (mem_en && addr < 32'(4 * RAM_WORDS)) mram[addr[31:2]] = mem_data;
        if (!m_halt) m_cyc = m_cyc + 1;
        if (req) m_halt = 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations. Inputs change 1 time unit
  // after a rising edge; DUT outputs are sampled on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_en   = 1'b1;
    addr     = a;
    mem_data = d;
    tick();
    mem_en   = 1'b0;
  endtask

  task automatic rd_check(input logic [31:0] a, input logic [31:0] exp, input string nm);
    addr = a;
    @(negedge clk);
    chk(nm, mem_out, exp);
    tick();
  endtask

  logic [31:0] c1, c2;

  initial begin
    reset_n  = 1'b0;
    mem_en   = 1'b0;
    addr     = A_STATUS;
    mem_data = 32'h0;
    req      = 1'b0;
    tx_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data", tx_data, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_status", mem_out, 32'h0000_0001);
    tick();
    reset_n = 1'b1;
    rd_check(A_CYCLE, 32'h0, "cycle_after_reset");

    // RAM round-trip
    wr(32'h0000_0014, 32'h0);
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_check(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd_10");
    rd_check(32'h0000_0014, 32'h0, "ram_rd_14");
    rd_check(32'h8000_0000, 32'h0, "unmapped_rd");
    // read during write returns the old value, new value next cycle
    mem_en = 1'b1; addr = 32'h0000_0010; mem_data = 32'h1234_5678;
    @(negedge clk);
    chk("ram_rd_during_wr", mem_out, 32'hDEAD_BEEF);
    tick();
    mem_en = 1'b0;
    rd_check(32'h0000_0010, 32'h1234_5678, "ram_rd_after_wr");
    rd_check(A_TX, 32'h0, "txdata_rd_zero");

    // Cycle counter delta over 5 edges
    addr = A_CYCLE;
    @(negedge clk);
    c1 = mem_out;
    repeat (5) @(negedge clk);
    c2 = mem_out;
    chk("cycle_delta", c2 - c1, 32'd5);
    tick();

    // Fill to full, overflow, then drain
    for (int i = 1; i <= 9; i++) wr(A_TX, 32'(i));
    rd_check(A_STATUS, 32'h0000_0806, "status_full_ovf");
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("drain_word", tx_data, 32'(i));
    end
    tick();
    tx_ready = 1'b0;
    rd_check(A_STATUS, 32'h0000_0005, "status_drained");

    // Overflow clear
    wr(A_STATUS, 32'h0000_00AB);
    rd_check(A_STATUS, 32'h0000_0001, "status_ovf_cleared");

    // Push while full with a simultaneous pop
    for (int i = 11; i <= 18; i++) wr(A_TX, 32'(i));
    tx_ready = 1'b1;
    wr(A_TX, 32'd42);
    tx_ready = 1'b0;
    rd_check(A_STATUS, 32'h0000_0802, "status_full_pop_push");
    tx_ready = 1'b1;
    for (int i = 12; i <= 19; i++) begin
      @(negedge clk);
      chk("drain2_word", tx_data, (i == 19) ? 32'd42 : 32'(i));
    end
    tick();
    tx_ready = 1'b0;

    // Queue 3 words, then halt
    wr(A_TX, 32'd7);
    wr(A_TX, 32'd8);
    wr(A_TX, 32'd9);
    req = 1'b1;
    tick();
    req = 1'b0;
    @(negedge clk);
    chk("halted_set", {31'b0, halted}, 32'h1);
    tick();
    rd_check(A_STATUS, 32'h0000_0308, "status_halted");
    addr = A_CYCLE;
    @(negedge clk);
    c1 = mem_out;
    repeat (10) @(negedge clk);
    c2 = mem_out;
    chk("cycle_frozen", c2, c1);
    tick();

    // Asynchronous reset pulse between edges
    addr = A_CYCLE;
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("async_tx_data", tx_data, 32'h0);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("async_cycle", mem_out, 32'h0);
    chk("async_halted", {31'b0, halted}, 32'h0);
    tick();
    rd_check(A_STATUS, 32'h0000_0001, "async_status");
    rd_check(32'h0000_0010, 32'h1234_5678, "ram_survives_reset");

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/data_responder.md
# data_responder

Responder end of the pipeline core's data-memory port: accepts the core's `mem_en`/`addr`/`mem_data` in the MEM stage and returns read data combinationally on `mem_out` within the same cycle. It contains a word-addressed data RAM and a small MMIO page holding a free-running cycle counter, a transmit FIFO drained by a valid/ready stream, and a status word. It also latches the core's `req` signal as a sticky halt flag.

## Interface
- `RAM_WORDS`, 1024: data RAM depth in 32-bit words; power of two, at least 16.
- `FIFO_DEPTH`, 8: transmit FIFO depth; power of two, 2 to 128.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset_n`  input  1  reset; one clock domain, asynchronous assert, active-low.
- `mem_en`  input  1  write enable from the core's MEM stage.
- `addr`  input  32  byte address from the core; `addr[1:0]` ignored.
- `mem_data`  input  32  write data.
- `req`  input  1  halt request from the core.
- `mem_out`  output  32  read data for `addr`; combinational.
- `tx_valid`  output  1  FIFO non-empty.
- `tx_data`  output  32  FIFO head word.
- `tx_ready`  input  1  downstream accepts the head word.
- `halted`  output  1  sticky; set by `req`.

## Operation
- Address decode uses `addr[31:2]`:
  - RAM region: byte addresses `0` to `4*RAM_WORDS-1`, index `addr[log2(RAM_WORDS)+1:2]`.
  - MMIO page:
    - `0xFFFF0000` is CYCLE (read-only).
    - `0xFFFF0004` is TXDATA (write-only; reads return 0).
    - `0xFFFF0008` is STATUS (read; writing any value clears `overflow`).
  - Any other address: reads return 0, writes are ignored.
- RAM reads are combinational. A write at the clock edge when `mem_en` is high and the address decodes to RAM. RAM contents are not cleared by reset.
- STATUS bit layout:
  - bit0 = empty
  - bit1 = full
  - bit2 = overflow
  - bit3 = halted
  - bits[15:8] = FIFO count, zero-extended
  - all other bits 0
- CYCLE: 32-bit counter, +1 every clock while `halted` is 0, frozen while it is 1, wraps `0xFFFFFFFF` -> 0.
- TX FIFO:
  - Circular buffer with read/write pointers and a count in `0..FIFO_DEPTH`.
  - Push: `mem_en` high and `addr` = TXDATA.
  - Pop: `tx_valid && tx_ready`.
  - Push while full with no pop: the word is dropped, `overflow` is set (sticky), and count is unchanged.
  - Push while full with a simultaneous pop: the push is accepted and count is unchanged.
  - Push while empty: count becomes 1; the word appears on `tx_data` the next cycle.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Overflow: a STATUS write clears `overflow`. If a dropped push and a STATUS write occur in the same cycle, the set wins; this cannot happen with a single-port core and is defined only for completeness.
- Halt: `req` high at a clock edge sets `halted`; only reset clears it. The FIFO keeps draining while halted, and RAM writes still occur.

## Timing
- Reset values (all outputs and state):
  - `halted` = 0, `tx_valid` = 0, `tx_data` = 0.
  - FIFO empty, `overflow` = 0, CYCLE = 0.
  - `mem_out` reflects the current decode.
- Reset asserts asynchronously and mid-operation: an in-flight push or pop is discarded and the FIFO returns to empty.
- Read latency is 0 cycles: `mem_out` is valid in the same cycle as `addr`.
- A write is visible to a read of the same address in the next cycle. A read during a write returns the old value.
- CYCLE read in cycle n returns the count of unhalted edges since reset.
- `tx_valid`, `tx_data`, and STATUS are derived from registered FIFO state only. They are never combinational from `tx_ready` or `mem_en`.

## Test plan
- **Reset, then RAM round-trip.** Release reset; write `0xDEADBEEF` to `0x00000010`; read it back the next cycle -> `mem_out` = `0xDEADBEEF`. Read `0x00000014` (written earlier with 0) -> 0. Read `0x80000000` -> 0.
- **Fill FIFO to full with `tx_ready` = 0, then drain.**
  - Push 1..8, then push 9 -> STATUS = `0x00000806` (count 8, full, overflow).
  - Assert `tx_ready` -> `tx_data` sequence is 1..8 with no 9; STATUS ends at `0x00000005`.
- **Push while full with a simultaneous pop.** FIFO full (8 words), `tx_ready` = 1, push 42 -> count stays 8, `overflow` stays 0, and 42 emerges after the 8 prior words.
- **Overflow clear.** After an overflow, write any value to `0xFFFF0008` -> the next STATUS read has bit2 = 0.
- **Cycle counter and halt.**
  - Read CYCLE at two points 5 edges apart -> difference = 5.
  - Pulse `req` -> `halted` = 1 next cycle; CYCLE constant over 10 cycles; STATUS bit3 = 1.
- **Asynchronous reset mid-traffic.** With 3 words queued, pulse `reset_n` low between edges -> `tx_valid` = 0 immediately, then STATUS = `0x00000001`, CYCLE = 0, `halted` = 0.
